jesd204_tx_data_buffer: RTL
===========================

Name: jesd204_tx_data_buffer

Overview:
- Elastic source stage directly upstream of the JESD204 TX link layer, in the device clock domain.
- Accepts transport-layer beats on a valid/ready stream and buffers them in a small FIFO.
- Feeds the link's tx_data input. Data release is aligned to the link's start-of-multiframe marker once a prefill level is reached.
- Detects and counts underflows, then re-aligns to the next multiframe after each one.

Parameters:
- NUM_LANES, 1, lanes carried per beat.
- DATA_PATH_WIDTH, 4, octets per lane per beat; DW = DATA_PATH_WIDTH*8*NUM_LANES.
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 beats.
- START_LEVEL, 8, FIFO level required before launch; legal range 1..2**DEPTH_LOG2.

Ports:
- clk  in  1  device clock; the only clock.
- resetn  in  1  asynchronous active-low reset.
- s_data  in  DW  input beat.
- s_valid  in  1  input beat valid.
- s_ready  out  1  buffer can accept a beat.
- tx_data  out  DW  beat presented to the link layer.
- tx_valid  out  1  tx_data carries buffered data this cycle.
- tx_ready  in  1  link layer consumes a beat every cycle this is high.
- tx_somf  in  DATA_PATH_WIDTH  start-of-multiframe markers for the current beat; only bit 0 is used.
- ctrl_enable  in  1  run enable.
- ctrl_clear_status  in  1  clears the underflow status.
- status_state  out  2  0 IDLE, 1 FILL, 2 RUN.
- status_level  out  DEPTH_LOG2+1  current FIFO occupancy.
- status_underflow  out  1  sticky underflow flag.
- status_underflow_count  out  16  saturating underflow counter.

Behaviour:
- Reset, asynchronous while resetn=0:
  - state IDLE, read/write pointers 0, level 0.
  - s_ready 0, tx_valid 0, tx_data 0.
  - status_underflow 0, status_underflow_count 0.
- FIFO:
  - Push = s_valid & s_ready. Pop is defined per state below.
  - Pointers are DEPTH_LOG2 bits and wrap modulo the depth.
  - Level rules: push and pop together leave level unchanged; push alone adds 1; pop alone subtracts 1.
  - s_ready = (state != IDLE) & (level < 2**DEPTH_LOG2). It does not depend on s_valid, so there is no combinational valid-to-ready path.
  - The head entry is read asynchronously so that tx_data is valid in the same cycle as the pop.
- tx_data / tx_valid:
  - When a pop occurs: tx_data = head entry, tx_valid = 1.
  - Otherwise: tx_data = 0, tx_valid = 0.
- IDLE:
  - Pointers and level are forced to 0; no push, no pop.
  - Leave for FILL when ctrl_enable=1; the transition takes effect next cycle.
- FILL:
  - Pushes are allowed.
  - Launch condition: tx_ready=1 & tx_somf[0]=1 & level >= START_LEVEL.
  - On launch: pop in this same cycle (the first beat goes out aligned to the multiframe start), and the next state is RUN.
  - Without the launch condition, no pop occurs.
- RUN, on every cycle with tx_ready=1:
  - If level > 0: pop.
  - If level = 0 (underflow): no pop, tx_data 0, tx_valid 0. Set status_underflow, increment status_underflow_count (saturating at 16'hFFFF), and go to FILL.
  - An underflow cycle with a simultaneous push still counts; that pushed beat stays in the FIFO.
- RUN with tx_ready=0: no pop; go to FILL (link dropped, realign). FIFO contents are retained.
- ctrl_enable=0 in any state: next state IDLE. The FIFO is flushed on entry; the cycle with ctrl_enable low still follows its state's pop/push rules.
- ctrl_clear_status: clears the sticky flag and the counter next cycle. If an underflow occurs in the same cycle, the underflow wins: flag=1, count=1.
- status_level and status_state reflect the registered values.

Test Plan:
- Reset/idle: hold resetn=0 with random inputs, then release with ctrl_enable=0 → s_ready=0, tx_valid=0, tx_data=0, status_state=0, level=0.
- Aligned launch: DEPTH_LOG2=4, START_LEVEL=8; push beats 1..10 with tx_ready=1 and tx_somf[0] pulsing every 8 cycles → no pop before level≥8. The first tx_valid=1 with tx_data=1 is on the first cycle with tx_somf[0]=1 after level≥8; data then comes out in order 2,3,... on consecutive cycles.
- Full: push 20 beats with tx_ready=0 → s_ready drops after 16 accepted; level=16; no data lost or reordered after launch.
- Underflow: in RUN, stop pushing → on the first empty cycle tx_valid=0, tx_data=0, count=1, flag=1, state=FILL. Relaunch only at a tx_somf[0] cycle with level≥8.
- Clear/saturation: force count to 16'hFFFF then underflow → count stays 16'hFFFF. Assert clear on the same cycle as an underflow → count=1, flag=1.
- Mid-run disable/reset: drop ctrl_enable in RUN → IDLE next cycle, level=0, s_ready=0. Assert resetn=0 mid-cycle → outputs zero immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/jesd204_tx_data_buffer.sv
// JESD204 TX data buffer: elastic FIFO stage in front of the link layer.
// Beats are buffered until a prefill level is reached, then released starting
// on a start-of-multiframe beat.  An empty FIFO while running is an underflow,
// which is counted and forces a fresh multiframe-aligned launch.
//
// Handshake: a beat moves on s_* only in a cycle where s_valid and s_ready are
// both high; s_ready is a function of registered state only (never of s_valid).
// On the link side tx_ready=1 means the link takes one beat that cycle;
// tx_valid=1 marks that the beat on tx_data is real buffered data.
module jesd204_tx_data_buffer #(
  parameter int NUM_LANES       = 1,
  parameter int DATA_PATH_WIDTH = 4,
  parameter int DEPTH_LOG2      = 4,
  parameter int START_LEVEL     = 8
) (
  input  logic                                     clk,
  input  logic                                     resetn,
  input  logic [DATA_PATH_WIDTH*8*NUM_LANES-1:0]   s_data,
  input  logic                                     s_valid,
  output logic                                     s_ready,
  output logic [DATA_PATH_WIDTH*8*NUM_LANES-1:0]   tx_data,
  output logic                                     tx_valid,
  input  logic                                     tx_ready,
  input  logic [DATA_PATH_WIDTH-1:0]               tx_somf,
  input  logic                                     ctrl_enable,
  input  logic                                     ctrl_clear_status,
  output logic [1:0]                               status_state,
  output logic [DEPTH_LOG2:0]                      status_level,
  output logic                                     status_underflow,
  output logic [15:0]                              status_underflow_count
);

  localparam int DW    = DATA_PATH_WIDTH * 8 * NUM_LANES;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [DEPTH_LOG2:0]   FULL_LVL  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   START_LVL = (DEPTH_LOG2 + 1)'(START_LEVEL);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [DW-1:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]     level_q, level_d;
  logic                    underflow_q, underflow_d;
  logic [15:0]             underflow_cnt_q, underflow_cnt_d;

  logic push;
  logic pop;
  logic underflow;
  logic flush;
  logic unused_somf;

  // Only the marker of the first octet slot decides alignment.
  assign unused_somf = ^tx_somf;

  assign s_ready = (state_q != ST_IDLE) && (level_q < FULL_LVL);
  assign push    = s_valid && s_ready;
  // Dropping the enable sends us to IDLE, which empties the FIFO on entry.
  assign flush   = (state_q == ST_IDLE) || !ctrl_enable;

  // Next-state, pop and underflow decode.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    underflow = 1'b0;
    unique case (state_q)
      ST_IDLE: state_d = ST_FILL;
      ST_FILL: begin
        // First beat leaves on the multiframe-start beat itself.
        if (tx_ready && tx_somf[0] && (level_q >= START_LVL)) begin
          pop     = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!tx_ready) begin
          // Link stopped consuming: alignment is lost, wait for a new multiframe.
          state_d = ST_FILL;
        end else if (level_q == '0) begin
          underflow = 1'b1;
          state_d   = ST_FILL;
        end else begin
          pop = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!ctrl_enable) state_d = ST_IDLE;
  end

  // Occupancy update from the push/pop pair.
  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Sticky underflow flag and saturating counter; an underflow beats a clear.
  always_comb begin
    underflow_d     = underflow_q;
    underflow_cnt_d = underflow_cnt_q;
    if (underflow) begin
      underflow_d = 1'b1;
      if (ctrl_clear_status)
        underflow_cnt_d = 16'd1;
      else if (underflow_cnt_q != 16'hFFFF)
        underflow_cnt_d = underflow_cnt_q + 16'd1;
    end else if (ctrl_clear_status) begin
      underflow_d     = 1'b0;
      underflow_cnt_d = 16'd0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FIFO pointers and level; both are cleared while idle or being flushed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      level_q <= level_d;
    end
  end

  // FIFO storage; no reset needed since only written entries are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  // Status registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      underflow_q     <= 1'b0;
      underflow_cnt_q <= 16'd0;
    end else begin
      underflow_q     <= underflow_d;
      underflow_cnt_q <= underflow_cnt_d;
    end
  end

  // Head is read combinationally so the beat appears in the cycle it is popped.
  assign tx_data  = pop ? mem_q[rd_ptr_q] : '0;
  assign tx_valid = pop;

  assign status_state           = state_q;
  assign status_level           = level_q;
  assign status_underflow       = underflow_q;
  assign status_underflow_count = underflow_cnt_q;

endmodule
